// File: rtl/snake_pkg.sv
// Shared types for the snake head controller: heading encoding, controller
// state encoding and the reverse-direction helper.
package snake_pkg;

    typedef enum logic [1:0] {
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        OVER
    } head_state_t;

    // True when b is the exact opposite heading of a.
    function automatic logic is_reverse(dir_t a, dir_t b);
        return ((a == DIR_UP)    && (b == DIR_DOWN))  ||
               ((a == DIR_DOWN)  && (b == DIR_UP))    ||
               ((a == DIR_LEFT)  && (b == DIR_RIGHT)) ||
               ((a == DIR_RIGHT) && (b == DIR_LEFT));
    endfunction

endpackage

// File: rtl/snake_head_ctrl_move_tick.sv
// Move tick generator: counts 0..TICK_DIV-1 while enabled and raises a
// one-cycle terminal-count pulse on the last count. The clear input holds
// the counter at zero.
module move_tick #(
    parameter int TICK_DIV = 12500000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic tick
);

    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] TC = CW'(TICK_DIV - 1);

    logic [CW-1:0] count;

    assign tick = enable && !clear && (count == TC);

    // Free-running interval counter, restarting from zero after each tick.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            if (count == TC) begin
                count <= '0;
            end else begin
                count <= count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/snake_head_ctrl.sv
// Snake head controller: owns head position, heading, length, game-over and
// the move strobe feeding the per-cell LED array.
// Build option: define WRAP_AROUND_EN to make the head wrap at the grid edges
// instead of colliding with them.
//
// state | meaning
// IDLE  | waiting for the first valid direction press, no move strobes
// RUN   | moving one cell per tick in the pending heading
// OVER  | wall or self collision, frozen until reset
module snake_head_ctrl
    import snake_pkg::*;
#(
    parameter int ROWS      = 16,
    parameter int COLS      = 16,
    parameter int TICK_DIV  = 12500000,
    parameter int START_I   = 10,
    parameter int START_J   = 7,
    parameter int START_LEN = 3,
    parameter int MAX_LEN   = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        btn_up,
    input  logic        btn_down,
    input  logic        btn_left,
    input  logic        btn_right,
    input  logic [4:0]  apple_i,
    input  logic [4:0]  apple_j,
    input  logic        self_hit,
    output logic [4:0]  next_i,
    output logic [4:0]  next_j,
    output logic [4:0]  i_head,
    output logic [4:0]  j_head,
    output logic [15:0] length,
    output logic        sys,
    output logic        gameOver,
    output logic        apple_eaten
);

    localparam logic signed [5:0] ROWS_S = 6'(ROWS);
    localparam logic signed [5:0] COLS_S = 6'(COLS);
    localparam logic [15:0]       MAX_L  = 16'(MAX_LEN);

    head_state_t state;
    dir_t        dir_q;
    dir_t        pend_q;
    dir_t        press_dir;
    dir_t        ref_dir;
    logic        press_vld;
    logic        press_ok;
    logic        tick;
    logic        wall;
    logic        hit;
    logic        eat;
    logic signed [5:0] ni_s;
    logic signed [5:0] nj_s;

    move_tick #(
        .TICK_DIV(TICK_DIV)
    ) u_move_tick (
        .clk    (clk),
        .reset  (reset),
        .enable (state == RUN),
        .clear  (state != RUN),
        .tick   (tick)
    );

    // Pick one press per cycle, up > down > left > right.
    always_comb begin
        press_vld = 1'b1;
        press_dir = DIR_RIGHT;
        if (btn_up) begin
            press_dir = DIR_UP;
        end else if (btn_down) begin
            press_dir = DIR_DOWN;
        end else if (btn_left) begin
            press_dir = DIR_LEFT;
        end else if (btn_right) begin
            press_dir = DIR_RIGHT;
        end else begin
            press_vld = 1'b0;
        end
    end

    // On a committing tick the pending heading becomes the committed one in
    // the same edge, so a coincident press is judged against it.
    assign ref_dir  = (tick && !hit) ? pend_q : dir_q;
    assign press_ok = press_vld && !is_reverse(ref_dir, press_dir);

    // Candidate next cell with signed headroom for the -1 / ROWS cases.
    always_comb begin
        ni_s = $signed({1'b0, i_head});
        nj_s = $signed({1'b0, j_head});
        wall = 1'b0;
        case (pend_q)
            DIR_UP:    ni_s = ni_s - 6'sd1;
            DIR_DOWN:  ni_s = ni_s + 6'sd1;
            DIR_LEFT:  nj_s = nj_s - 6'sd1;
            default:   nj_s = nj_s + 6'sd1;
        endcase
`ifdef WRAP_AROUND_EN
        if (ni_s < 6'sd0) begin
            ni_s = ROWS_S - 6'sd1;
        end else if (ni_s >= ROWS_S) begin
            ni_s = 6'sd0;
        end
        if (nj_s < 6'sd0) begin
            nj_s = COLS_S - 6'sd1;
        end else if (nj_s >= COLS_S) begin
            nj_s = 6'sd0;
        end
`else
        wall = (ni_s < 6'sd0) || (ni_s >= ROWS_S) ||
               (nj_s < 6'sd0) || (nj_s >= COLS_S);
`endif
    end

    assign next_i = ni_s[4:0];
    assign next_j = nj_s[4:0];
    assign hit    = wall || self_hit;
    assign eat    = (next_i == apple_i) && (next_j == apple_j);

    // Controller FSM: heading capture, move commit and collision handling.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            i_head      <= 5'(START_I);
            j_head      <= 5'(START_J);
            length      <= 16'(START_LEN);
            dir_q       <= DIR_RIGHT;
            pend_q      <= DIR_RIGHT;
            sys         <= 1'b0;
            apple_eaten <= 1'b0;
            gameOver    <= 1'b0;
        end else begin
            sys         <= 1'b0;
            apple_eaten <= 1'b0;
            case (state)
                IDLE: begin
                    if (press_ok) begin
                        pend_q <= press_dir;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    if (press_ok) begin
                        pend_q <= press_dir;
                    end
                    if (tick) begin
                        sys <= 1'b1;
                        if (hit) begin
                            gameOver <= 1'b1;
                            state    <= OVER;
                        end else begin
                            i_head      <= next_i;
                            j_head      <= next_j;
                            dir_q       <= pend_q;
                            apple_eaten <= eat;
                            if (eat && (length < MAX_L)) begin
                                length <= length + 16'd1;
                            end
                        end
                    end
                end
                OVER: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_snake_head_ctrl.sv
// Directed testbench for snake_head_ctrl with a short tick (4 cycles) and a
// small length ceiling (4) so saturation is reachable.
// Expectations follow WRAP_AROUND_EN when it is defined for the build.
module tb_snake_head_ctrl;

    logic        clk;
    logic        reset;
    logic        btn_up, btn_down, btn_left, btn_right;
    logic [4:0]  apple_i, apple_j;
    logic        self_hit;
    logic [4:0]  next_i, next_j, i_head, j_head;
    logic [15:0] length;
    logic        sys, gameOver, apple_eaten;

    int checks   = 0;
    int failures = 0;

    snake_head_ctrl #(
        .ROWS(16), .COLS(16), .TICK_DIV(4),
        .START_I(10), .START_J(7), .START_LEN(3), .MAX_LEN(4)
    ) dut (
        .clk(clk), .reset(reset),
        .btn_up(btn_up), .btn_down(btn_down),
        .btn_left(btn_left), .btn_right(btn_right),
        .apple_i(apple_i), .apple_j(apple_j), .self_hit(self_hit),
        .next_i(next_i), .next_j(next_j),
        .i_head(i_head), .j_head(j_head), .length(length),
        .sys(sys), .gameOver(gameOver), .apple_eaten(apple_eaten)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $display("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
            $error("%s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive a one-cycle press starting at the current negedge.
    task automatic press(input logic u, input logic d, input logic l, input logic r);
        btn_up = u; btn_down = d; btn_left = l; btn_right = r;
        @(negedge clk);
        btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
    endtask

    // Advance negedge by negedge until sys is seen or the budget runs out.
    task automatic wait_sys(input int max, output int n, output logic ok);
        n  = 0;
        ok = 1'b0;
        while (n < max && !ok) begin
            @(negedge clk);
            n++;
            if (sys) ok = 1'b1;
        end
    endtask

    task automatic count_sys(input int cycles, output int cnt);
        cnt = 0;
        for (int k = 0; k < cycles; k++) begin
            @(negedge clk);
            if (sys) cnt++;
        end
    endtask

    int   n;
    int   cnt;
    logic ok;

    initial begin
        reset = 0; btn_up = 0; btn_down = 0; btn_left = 0; btn_right = 0;
        apple_i = 0; apple_j = 0; self_hit = 0;
        repeat (3) @(negedge clk);
        chk("rst_i", i_head, 10);
        chk("rst_j", j_head, 7);
        chk("rst_len", length, 3);
        chk("rst_sys", sys, 0);
        chk("rst_go", gameOver, 0);
        chk("rst_ae", apple_eaten, 0);
        chk("rst_next_i", next_i, 10);
        chk("rst_next_j", next_j, 8);

        reset = 1;
        count_sys(20, cnt);
        chk("idle_no_sys", cnt, 0);
        chk("idle_j", j_head, 7);
        chk("idle_go", gameOver, 0);

        // Start moving right; apple two cells ahead.
        apple_i = 10; apple_j = 9;
        press(0, 0, 0, 1);
        wait_sys(16, n, ok);
        chk("mv1_ok", ok, 1);
        chk("mv1_i", i_head, 10);
        chk("mv1_j", j_head, 8);
        chk("mv1_len", length, 3);
        chk("mv1_ae", apple_eaten, 0);

        wait_sys(16, n, ok);
        chk("mv2_period", n, 4);
        chk("mv2_j", j_head, 9);
        chk("eat_len", length, 4);
        chk("eat_ae", apple_eaten, 1);
        @(negedge clk);
        chk("eat_ae_1cyc", apple_eaten, 0);
        chk("sys_1cyc", sys, 0);

        // Second apple at the length ceiling.
        apple_i = 10; apple_j = 10;
        wait_sys(16, n, ok);
        chk("mv3_j", j_head, 10);
        chk("sat_len", length, 4);
        chk("sat_ae", apple_eaten, 1);
        apple_i = 0; apple_j = 0;

        // Reverse press ignored.
        press(0, 0, 1, 0);
        wait_sys(16, n, ok);
        chk("rev_i", i_head, 10);
        chk("rev_j", j_head, 11);

        press(1, 0, 0, 0);
        wait_sys(16, n, ok);
        chk("up_i", i_head, 9);
        chk("up_j", j_head, 11);

        press(0, 0, 1, 0);
        wait_sys(16, n, ok);
        chk("left_i", i_head, 9);
        chk("left_j", j_head, 10);

        press(0, 1, 0, 0);
        wait_sys(16, n, ok);
        chk("down_i", i_head, 10);
        chk("down_j", j_head, 10);

        press(0, 0, 0, 1);
        wait_sys(16, n, ok);
        chk("right_j", j_head, 11);
        for (int k = 12; k <= 15; k++) begin
            wait_sys(16, n, ok);
            chk("edge_run_j", j_head, k);
        end
        chk("edge_run_i", i_head, 10);

        wait_sys(16, n, ok);
        chk("edge_sys", ok, 1);
`ifdef WRAP_AROUND_EN
        chk("wrap_go", gameOver, 0);
        chk("wrap_i", i_head, 10);
        chk("wrap_j", j_head, 0);
`else
        chk("wall_go", gameOver, 1);
        chk("wall_i", i_head, 10);
        chk("wall_j", j_head, 15);
        chk("wall_len", length, 4);
        chk("wall_ae", apple_eaten, 0);
        press(1, 0, 0, 0);
        count_sys(12, cnt);
        chk("over_no_sys", cnt, 0);
        chk("over_next_i", next_i, 10);
        chk("over_next_j", next_j, 16);
        chk("over_go", gameOver, 1);
`endif

        // Fresh game.
        reset = 0;
        @(negedge clk);
        reset = 1;
        press(0, 0, 1, 1);
        count_sys(10, cnt);
        chk("prio_left_no_run", cnt, 0);
        chk("prio_left_next_j", next_j, 8);

        press(0, 1, 0, 1);
        chk("prio_down_next_i", next_i, 11);
        chk("prio_down_next_j", next_j, 7);
        apple_i = 11; apple_j = 7; self_hit = 1;
        wait_sys(16, n, ok);
        chk("self_sys", ok, 1);
        chk("self_go", gameOver, 1);
        chk("self_i", i_head, 10);
        chk("self_j", j_head, 7);
        chk("self_len", length, 3);
        chk("self_ae", apple_eaten, 0);
        repeat (2) @(negedge clk);

        // Asynchronous reset while in OVER.
        reset = 0;
        #1;
        chk("areset_i", i_head, 10);
        chk("areset_j", j_head, 7);
        chk("areset_len", length, 3);
        chk("areset_go", gameOver, 0);
        chk("areset_sys", sys, 0);
        @(negedge clk);
        reset = 1; self_hit = 0;
        count_sys(10, cnt);
        chk("areset_idle", cnt, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
